// File: rtl/rmgmt_mac_ext_if.sv
// Execute-stage link between RISC-MGMT and the MAC extension.
// The master side dispatches operands and can flush the operation.
// The slave side reports busy, done, register write and exception status.
interface rmgmt_mac_ext_if;
  // dispatch side, driven by RISC-MGMT
  logic        ex_start;
  logic [2:0]  ex_funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  // status / writeback side, driven by the extension
  logic        ex_busy;
  logic        ex_done;
  logic        reg_wen;
  logic [31:0] reg_wdata;
  logic        exception;
  logic [4:0]  ex_cause;

  modport master (
    output ex_start, ex_funct3, rs1_data, rs2_data, flush,
    input  ex_busy, ex_done, reg_wen, reg_wdata, exception, ex_cause
  );

  modport slave (
    input  ex_start, ex_funct3, rs1_data, rs2_data, flush,
    output ex_busy, ex_done, reg_wen, reg_wdata, exception, ex_cause
  );
endinterface

// File: rtl/rmgmt_mac_ext.sv
// MAC extension: unsigned 32-bit multiply-accumulate with a private accumulator.
// Latency: MAC completes after 32/BITS_PER_CYCLE+1 cycles; CLR, RDACC and illegal ops complete after 1 cycle.
// No backpressure: RISC-MGMT stalls on ex_busy, and ex_start is ignored outside IDLE.
module rmgmt_mac_ext #(
  parameter int BITS_PER_CYCLE = 4,
  parameter int ILLEGAL_CAUSE  = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  rmgmt_mac_ext_if.slave ext
);

  localparam int ITER = 32 / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [2:0] F3_MAC   = 3'd0;
  localparam logic [2:0] F3_CLR   = 3'd1;
  localparam logic [2:0] F3_RDACC = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2,
    EXC  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    acc_q, acc_d;
  logic [31:0]    result_q, result_d;
  logic [31:0]    mcand_q, mcand_d;
  logic [31:0]    mplier_q, mplier_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2:0]     f3_q, f3_d;

  // Multiplier digit retired this cycle, zero-extended to the full operand width.
  logic [31:0]    digit;
  logic [31:0]    partial;
  logic [31:0]    sum;

  logic           busy_o;
  logic           done_o;
  logic           wen_o;
  logic [31:0]    wdata_o;
  logic           exc_o;
  logic [4:0]     cause_o;

  // State and datapath registers; reset clears everything, including a MAC in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      f3_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      f3_q     <= f3_d;
    end
  end

  // Next-state, shift-add datapath and the cycle's status outputs.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    f3_d     = f3_q;

    busy_o   = 1'b0;
    done_o   = 1'b0;
    wen_o    = 1'b0;
    wdata_o  = '0;
    exc_o    = 1'b0;
    cause_o  = '0;

    digit                        = '0;
    digit[BITS_PER_CYCLE-1:0]    = mplier_q[BITS_PER_CYCLE-1:0];
    partial                      = mcand_q * digit;
    sum                          = result_q + partial;

    case (state_q)
      IDLE: begin
        // A dispatch that coincides with a flush is dropped outright.
        if (ext.ex_start && !ext.flush) begin
          f3_d     = ext.ex_funct3;
          mcand_d  = ext.rs1_data;
          mplier_d = ext.rs2_data;
          count_d  = '0;
          case (ext.ex_funct3)
            F3_MAC: begin
              result_d = '0;
              state_d  = EXEC;
            end
            F3_CLR: begin
              result_d = '0;
              state_d  = DONE;
            end
            F3_RDACC: begin
              result_d = acc_q;
              state_d  = DONE;
            end
            default: state_d = EXC;
          endcase
        end
      end

      EXEC: begin
        busy_o = 1'b1;
        if (ext.flush) begin
          // Abandon the partial product; the accumulator was never touched.
          state_d = IDLE;
        end else begin
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          count_d  = count_q + CW'(1);
          if (count_q == CW'(ITER - 1)) begin
            // Final digit: fold the accumulator in so DONE only has to present it.
            result_d = sum + acc_q;
            state_d  = DONE;
          end else begin
            result_d = sum;
          end
        end
      end

      DONE: begin
        done_o  = 1'b1;
        wdata_o = result_q;
        wen_o   = !ext.flush;
        // Commit to the accumulator only when the writeback itself is not flushed.
        if (!ext.flush) begin
          acc_d = (f3_q == F3_CLR) ? '0 : result_q;
        end
        state_d = IDLE;
      end

      EXC: begin
        exc_o   = 1'b1;
        cause_o = 5'(ILLEGAL_CAUSE);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign ext.ex_busy   = busy_o;
  assign ext.ex_done   = done_o;
  assign ext.reg_wen   = wen_o;
  assign ext.reg_wdata = wdata_o;
  assign ext.exception = exc_o;
  assign ext.ex_cause  = cause_o;

endmodule

// File: tb/tb_rmgmt_mac_ext.sv
// Bench for rmgmt_mac_ext: a 4-bit/cycle instance and a 1-bit/cycle instance.
// Directed table, randomized ops against an arithmetic accumulator model, and flush/reset corners.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_rmgmt_mac_ext;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  rmgmt_mac_ext_if if4 ();
  rmgmt_mac_ext_if if1 ();

  rmgmt_mac_ext #(.BITS_PER_CYCLE(4), .ILLEGAL_CAUSE(2)) dut4 (.CLK(CLK), .nRST(nRST), .ext(if4.slave));
  rmgmt_mac_ext #(.BITS_PER_CYCLE(1), .ILLEGAL_CAUSE(2)) dut1 (.CLK(CLK), .nRST(nRST), .ext(if1.slave));

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        wen;
    logic        exc;
    logic [4:0]  cause;
    logic [31:0] wdata;
  } obs_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_wdata;
    int          exp_lat;
    logic        exp_exc;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc_m [2];

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 1) o = '{if1.ex_busy, if1.ex_done, if1.reg_wen, if1.exception, if1.ex_cause, if1.reg_wdata};
    else          o = '{if4.ex_busy, if4.ex_done, if4.reg_wen, if4.exception, if4.ex_cause, if4.reg_wdata};
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel == 1) begin
      if1.ex_start = st; if1.ex_funct3 = f3; if1.rs1_data = a; if1.rs2_data = b;
    end else begin
      if4.ex_start = st; if4.ex_funct3 = f3; if4.rs1_data = a; if4.rs2_data = b;
    end
  endtask

  task automatic set_flush(input int sel, input logic v);
    if (sel == 1) if1.flush = v;
    else          if4.flush = v;
  endtask

  // Dispatch one op and check its completion cycle and writeback; called at posedge+1.
  task automatic run_op(input int sel, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_wdata, input int exp_lat, input logic exp_exc,
                        input string name);
    obs_t o;
    int   lat;
    lat = 0;
    o   = '0;
    drive(sel, 1'b1, f3, a, b);
    @(posedge CLK); #1;
    drive(sel, 1'b0, 3'd0, 32'd0, 32'd0);
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      o = sample(sel);
      if (o.done || o.exc) begin
        lat = c;
        break;
      end
      if (!o.busy) chk({name, "_busy"}, 64'(o.busy), 64'd1);
      @(posedge CLK); #1;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_done"},  64'(o.done),  64'(!exp_exc));
    chk({name, "_wen"},   64'(o.wen),   64'(!exp_exc));
    chk({name, "_wdata"}, 64'(o.wdata), exp_exc ? 64'd0 : 64'(exp_wdata));
    chk({name, "_exc"},   64'(o.exc),   64'(exp_exc));
    chk({name, "_cause"}, 64'(o.cause), exp_exc ? 64'd2 : 64'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk({name, "_idle_after"}, 64'(sample(sel)), 64'd0);
    @(posedge CLK); #1;
  endtask

  // Reference model: accumulator semantics computed directly from the op definition.
  task automatic model_op(input int sel, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input string name);
    logic [63:0] prod;
    logic [31:0] exp;
    int          iter;
    iter = (sel == 1) ? 32 : 8;
    prod = 64'(a) * 64'(b);
    case (f3)
      3'd0: begin
        exp = acc_m[sel] + prod[31:0];
        run_op(sel, f3, a, b, exp, iter + 1, 1'b0, name);
        acc_m[sel] = exp;
      end
      3'd1: begin
        run_op(sel, f3, a, b, 32'd0, 1, 1'b0, name);
        acc_m[sel] = 32'd0;
      end
      3'd2: run_op(sel, f3, a, b, acc_m[sel], 1, 1'b0, name);
      default: run_op(sel, f3, a, b, 32'd0, 1, 1'b1, name);
    endcase
  endtask

  task automatic random_ops(input int sel, input int n);
    int          r;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      f3 = 3'd0;
      else if (r == 5) f3 = 3'd1;
      else if (r <= 7) f3 = 3'd2;
      else             f3 = 3'($urandom_range(3, 7));
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
      b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
      model_op(sel, f3, a, b, $sformatf("rand%0d_%0d", sel, i));
    end
  endtask

  vec_t tbl [11];

  initial begin
    obs_t o;
    int   lat;

    tbl[0]  = '{3'd0, 32'd3,          32'd5,          32'h0000000F, 9, 1'b0};
    tbl[1]  = '{3'd0, 32'hFFFFFFFF,   32'd2,          32'h0000000D, 9, 1'b0};
    tbl[2]  = '{3'd2, 32'd0,          32'd0,          32'h0000000D, 1, 1'b0};
    tbl[3]  = '{3'd0, 32'h00010000,   32'h00010000,   32'h0000000D, 9, 1'b0};
    tbl[4]  = '{3'd1, 32'd0,          32'd0,          32'h00000000, 1, 1'b0};
    tbl[5]  = '{3'd2, 32'd0,          32'd0,          32'h00000000, 1, 1'b0};
    tbl[6]  = '{3'd0, 32'd7,          32'd6,          32'h0000002A, 9, 1'b0};
    tbl[7]  = '{3'd7, 32'd1,          32'd1,          32'h00000000, 1, 1'b1};
    tbl[8]  = '{3'd2, 32'd0,          32'd0,          32'h0000002A, 1, 1'b0};
    tbl[9]  = '{3'd3, 32'd9,          32'd9,          32'h00000000, 1, 1'b1};
    tbl[10] = '{3'd2, 32'd0,          32'd0,          32'h0000002A, 1, 1'b0};

    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    set_flush(0, 1'b0);
    set_flush(1, 1'b0);
    acc_m[0] = 32'd0;
    acc_m[1] = 32'd0;

    // Reset state
    #2;
    chk("reset_outputs4", 64'(sample(0)), 64'd0);
    chk("reset_outputs1", 64'(sample(1)), 64'd0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK); #1;

    // Directed table on the 4-bit/cycle instance
    for (int i = 0; i < 11; i++)
      run_op(0, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp_wdata, tbl[i].exp_lat, tbl[i].exp_exc,
             $sformatf("vec%0d", i));
    acc_m[0] = 32'h2A;

    // 1-bit/cycle instance: same multiply completes in cycle 33
    run_op(1, 3'd0, 32'd3, 32'd5, 32'h0000000F, 33, 1'b0, "bits1_mac");
    acc_m[1] = 32'h0F;

    // Flush during EXEC cycle 3
    drive(0, 1'b1, 3'd0, 32'd9, 32'd9);
    @(posedge CLK); #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) begin
      @(negedge CLK);
      chk("flush_exec_busy_pre", 64'(sample(0).busy), 64'd1);
      @(posedge CLK); #1;
    end
    set_flush(0, 1'b1);
    @(negedge CLK);
    chk("flush_exec_busy_c3", 64'(sample(0).busy), 64'd1);
    @(posedge CLK); #1;
    set_flush(0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      o = sample(0);
      chk("flush_exec_quiet", 64'({o.busy, o.done, o.wen}), 64'd0);
      @(posedge CLK); #1;
    end
    model_op(0, 3'd2, 32'd0, 32'd0, "flush_exec_rdacc");

    // Flush during DONE
    drive(0, 1'b1, 3'd0, 32'd2, 32'd3);
    @(posedge CLK); #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (8) @(posedge CLK);
    #1 set_flush(0, 1'b1);
    @(negedge CLK);
    o = sample(0);
    chk("flush_done_done",  64'(o.done),  64'd1);
    chk("flush_done_wen",   64'(o.wen),   64'd0);
    chk("flush_done_wdata", 64'(o.wdata), 64'(acc_m[0] + 32'd6));
    @(posedge CLK); #1;
    set_flush(0, 1'b0);
    model_op(0, 3'd2, 32'd0, 32'd0, "flush_done_rdacc");

    // Start coinciding with flush in IDLE is dropped
    drive(0, 1'b1, 3'd2, 32'd0, 32'd0);
    set_flush(0, 1'b1);
    @(posedge CLK); #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_flush(0, 1'b0);
    repeat (3) begin
      @(negedge CLK);
      chk("flush_start_dropped", 64'(sample(0)), 64'd0);
      @(posedge CLK); #1;
    end

    // ex_start during EXEC is ignored
    drive(0, 1'b1, 3'd0, 32'd4, 32'd4);
    @(posedge CLK); #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(posedge CLK); #1;
    drive(0, 1'b1, 3'd1, 32'd0, 32'd0);
    @(posedge CLK); #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    lat = 0;
    o   = '0;
    for (int c = 3; c <= 60; c++) begin
      @(negedge CLK);
      o = sample(0);
      if (o.done || o.exc) begin
        lat = c;
        break;
      end
      @(posedge CLK); #1;
    end
    chk("ignore_start_latency", 64'(lat), 64'd9);
    chk("ignore_start_wdata",   64'(o.wdata), 64'(acc_m[0] + 32'd16));
    acc_m[0] = acc_m[0] + 32'd16;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("ignore_start_no_extra", 64'(sample(0)), 64'd0);
    @(posedge CLK); #1;

    // Randomized ops against the accumulator model
    random_ops(0, 30);
    random_ops(1, 5);

    // Reset asserted mid-EXEC
    drive(0, 1'b1, 3'd0, 32'd11, 32'd13);
    @(posedge CLK); #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("mid_reset_outputs4", 64'(sample(0)), 64'd0);
    chk("mid_reset_outputs1", 64'(sample(1)), 64'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    acc_m[0] = 32'd0;
    acc_m[1] = 32'd0;
    @(posedge CLK); #1;
    model_op(0, 3'd2, 32'd0, 32'd0, "post_reset_rdacc4");
    model_op(1, 3'd2, 32'd0, 32'd0, "post_reset_rdacc1");
    model_op(1, 3'd0, 32'd3, 32'd5, "post_reset_bits1_mac");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
